// File: rtl/control_unit_if.sv
// rtl/control_unit_if.sv - control bundle between the multicycle control FSM and the MIPS datapath
interface control_unit_if #(
    parameter int WIDTH = 32
);
    logic [5:0]       op;
    logic [5:0]       Funct;
    logic             zero_i;
    logic             PCen;
    logic             IorD;
    logic             Ori;
    logic             MemWrite;
    logic             IRWrite;
    logic             RegDst;
    logic             MemtoReg;
    logic             RegWrite;
    logic             ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [2:0]       ALUControl;
    logic             PCsrc;
    logic             illegal_o;
    logic [WIDTH-1:0] instr_count_o;

    modport master (
        input  op, Funct, zero_i,
        output PCen, IorD, Ori, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, ALUControl, PCsrc, illegal_o, instr_count_o
    );

    modport slave (
        output op, Funct, zero_i,
        input  PCen, IorD, Ori, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, ALUControl, PCsrc, illegal_o, instr_count_o
    );
endinterface

// File: rtl/control_unit.sv
// rtl/control_unit.sv - multicycle MIPS control FSM with retired-instruction counter
module control_unit #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          reset,
    control_unit_if.master bus
);
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_IN   = 6'b111111;

    typedef enum logic [3:0] {
        S_INIT, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECUTE, S_ALUWB, S_IEXEC, S_IWB, S_BRANCH, S_JUMP
    } state_t;

    typedef struct packed {
        logic       pcwrite;
        logic       branch;
        logic       iord;
        logic       ori;
        logic       memwrite;
        logic       irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [2:0] aluctrl;
        logic       pcsrc;
    } ctrl_t;

    state_t           state;
    state_t           nxt;
    ctrl_t            ctrl;
    logic [5:0]       op_r;
    logic [5:0]       funct_r;
    logic [5:0]       sel_op;
    logic [5:0]       sel_funct;
    logic             bad;
    logic             retire;
    logic [WIDTH-1:0] count;

    function automatic logic funct_ok(input logic [5:0] f);
        return (f == 6'b100000) || (f == 6'b100010) || (f == 6'b100100) ||
               (f == 6'b100101) || (f == 6'b101010);
    endfunction

    function automatic logic [2:0] funct_alu(input logic [5:0] f);
        logic [2:0] a;
        case (f)
            6'b100000: a = 3'b010;
            6'b100010: a = 3'b110;
            6'b100100: a = 3'b000;
            6'b100101: a = 3'b001;
            6'b101010: a = 3'b111;
            default:   a = 3'b000;
        endcase
        return a;
    endfunction

    // Outputs for the state being entered; o/f are the opcode/funct that state will act on.
    function automatic ctrl_t ctrl_of(input state_t s, input logic [5:0] o, input logic [5:0] f);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.irwrite = 1'b1;
                c.alusrcb = 2'b01;
                c.aluctrl = 3'b010;
                c.pcwrite = 1'b1;
            end
            S_DECODE: begin
                c.alusrcb = 2'b11;
                c.aluctrl = 3'b010;
            end
            S_MEMADR: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
                c.aluctrl = 3'b010;
            end
            S_MEMREAD: c.iord = 1'b1;
            S_MEMWB: begin
                c.memtoreg = 1'b1;
                c.regwrite = 1'b1;
            end
            S_MEMWRITE: begin
                c.iord     = 1'b1;
                c.memwrite = 1'b1;
            end
            S_EXECUTE: begin
                c.alusrca = 1'b1;
                c.aluctrl = funct_alu(f);
            end
            S_ALUWB: begin
                c.regdst   = 1'b1;
                c.regwrite = 1'b1;
            end
            S_IEXEC: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
                c.aluctrl = (o == OP_ORI) ? 3'b001 : 3'b010;
                c.ori     = (o == OP_IN);
            end
            // Ori and the ALU operation stay as in IEXEC so the write-back value is stable.
            S_IWB: begin
                c.regwrite = 1'b1;
                c.aluctrl  = (o == OP_ORI) ? 3'b001 : 3'b010;
                c.ori      = (o == OP_IN);
            end
            S_BRANCH: begin
                c.alusrca = 1'b1;
                c.aluctrl = 3'b110;
                c.pcsrc   = 1'b1;
                c.branch  = 1'b1;
            end
            S_JUMP: begin
                c.aluctrl = 3'b011;
                c.pcwrite = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        nxt = state;
        bad = 1'b0;
        case (state)
            S_INIT:   nxt = S_FETCH;
            S_FETCH:  nxt = S_DECODE;
            S_DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW:           nxt = S_MEMADR;
                    OP_R:                   if (funct_ok(bus.Funct)) nxt = S_EXECUTE;
                                            else bad = 1'b1;
                    OP_ADDI, OP_ORI, OP_IN: nxt = S_IEXEC;
                    OP_BEQ:                 nxt = S_BRANCH;
                    OP_J:                   nxt = S_JUMP;
                    default:                bad = 1'b1;
                endcase
                if (bad) nxt = S_FETCH;
            end
            S_MEMADR:  nxt = (op_r == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD: nxt = S_MEMWB;
            S_EXECUTE: nxt = S_ALUWB;
            S_IEXEC:   nxt = S_IWB;
            default:   nxt = S_FETCH;
        endcase
    end

    assign retire = (state == S_MEMWB) || (state == S_MEMWRITE) || (state == S_ALUWB) ||
                    (state == S_IWB) || (state == S_BRANCH) || (state == S_JUMP);

    // The instruction register is only trusted during DECODE; afterwards the captured copy is used.
    assign sel_op    = (state == S_DECODE) ? bus.op    : op_r;
    assign sel_funct = (state == S_DECODE) ? bus.Funct : funct_r;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_INIT;
            ctrl    <= '0;
            op_r    <= '0;
            funct_r <= '0;
            count   <= '0;
        end else begin
            state <= nxt;
            ctrl  <= ctrl_of(nxt, sel_op, sel_funct);
            if (state == S_DECODE) begin
                op_r    <= bus.op;
                funct_r <= bus.Funct;
            end
            if (retire) count <= count + WIDTH'(1);
        end
    end

    assign bus.PCen          = ctrl.pcwrite | (ctrl.branch & bus.zero_i);
    assign bus.IorD          = ctrl.iord;
    assign bus.Ori           = ctrl.ori;
    assign bus.MemWrite      = ctrl.memwrite;
    assign bus.IRWrite       = ctrl.irwrite;
    assign bus.RegDst        = ctrl.regdst;
    assign bus.MemtoReg      = ctrl.memtoreg;
    assign bus.RegWrite      = ctrl.regwrite;
    assign bus.ALUSrcA       = ctrl.alusrca;
    assign bus.ALUSrcB       = ctrl.alusrcb;
    assign bus.ALUControl    = ctrl.aluctrl;
    assign bus.PCsrc         = ctrl.pcsrc;
    assign bus.illegal_o     = (state == S_DECODE) && bad;
    assign bus.instr_count_o = count;
endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - scoreboard bench for control_unit with randomized instruction stream
module tb_control_unit;
    localparam int W = 32;

    localparam int P_PCEN = 15, P_IORD = 14, P_ORI = 13, P_MW = 12, P_IRW = 11, P_RD = 10;
    localparam int P_M2R = 9, P_RW = 8, P_SA = 7, P_SB = 5, P_AC = 2, P_PCS = 1, P_ILL = 0;

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_ORI = 6'b001101;
    localparam logic [5:0] OP_J = 6'b000010, OP_IN = 6'b111111;
    localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100;
    localparam logic [5:0] F_OR = 6'b100101, F_SLT = 6'b101010;

    logic clk;
    logic reset;

    control_unit_if #(.WIDTH(W)) bus();
    control_unit #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0]  v;
        logic [W-1:0] c;
        logic [63:0]  tag;
    } exp_t;

    exp_t         q[$];
    exp_t         m_e;
    logic [15:0]  m_act;
    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] cnt = '0;
    int           force_zero = -1;

    function automatic logic [15:0] b(input int pos);
        return 16'(1) << pos;
    endfunction
    function automatic logic [15:0] sb(input logic [1:0] x);
        return 16'(x) << P_SB;
    endfunction
    function automatic logic [15:0] ac(input logic [2:0] x);
        return 16'(x) << P_AC;
    endfunction

    function automatic logic [2:0] alu_for(input logic [5:0] f);
        logic [2:0] a;
        case (f)
            F_ADD:   a = 3'b010;
            F_SUB:   a = 3'b110;
            F_AND:   a = 3'b000;
            F_OR:    a = 3'b001;
            F_SLT:   a = 3'b111;
            default: a = 3'b000;
        endcase
        return a;
    endfunction

    function automatic bit legal_funct(input logic [5:0] f);
        return f inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT};
    endfunction
    function automatic bit legal_op(input logic [5:0] o);
        return o inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_ORI, OP_J, OP_IN};
    endfunction

    // One clock cycle of stimulus: inputs change 1 ns after the edge, expectation goes to the scoreboard.
    task automatic step(input logic [15:0] v_in, input bit br, input bit dec,
                        input logic [5:0] o, input logic [5:0] f, input logic [63:0] tag);
        exp_t        e;
        logic [15:0] v;
        v = v_in;
        @(posedge clk);
        #1;
        bus.zero_i = (force_zero < 0) ? 1'($urandom) : (force_zero != 0);
        if (dec) begin
            bus.op    = o;
            bus.Funct = f;
        end else begin
            bus.op    = 6'($urandom);
            bus.Funct = 6'($urandom);
        end
        if (br && bus.zero_i) v[P_PCEN] = 1'b1;
        e.v   = v;
        e.c   = cnt;
        e.tag = tag;
        q.push_back(e);
    endtask

    task automatic run_instr(input logic [5:0] o, input logic [5:0] f);
        bit         ok;
        logic [2:0] a;
        logic [15:0] oi;
        ok = legal_op(o) && ((o != OP_R) || legal_funct(f));
        step(b(P_PCEN) | b(P_IRW) | sb(2'b01) | ac(3'b010), 0, 0, o, f, "FETCH");
        step(sb(2'b11) | ac(3'b010) | (ok ? 16'h0 : b(P_ILL)), 0, 1, o, f, "DECODE");
        if (ok) begin
            case (o)
                OP_LW: begin
                    step(b(P_SA) | sb(2'b10) | ac(3'b010), 0, 0, o, f, "MEMADR");
                    step(b(P_IORD), 0, 0, o, f, "MEMREAD");
                    step(b(P_M2R) | b(P_RW), 0, 0, o, f, "MEMWB");
                end
                OP_SW: begin
                    step(b(P_SA) | sb(2'b10) | ac(3'b010), 0, 0, o, f, "MEMADR");
                    step(b(P_IORD) | b(P_MW), 0, 0, o, f, "MEMWRITE");
                end
                OP_R: begin
                    step(b(P_SA) | sb(2'b00) | ac(alu_for(f)), 0, 0, o, f, "EXECUTE");
                    step(b(P_RD) | b(P_RW), 0, 0, o, f, "ALUWB");
                end
                OP_BEQ: step(b(P_SA) | ac(3'b110) | b(P_PCS), 1, 0, o, f, "BRANCH");
                OP_J:   step(ac(3'b011) | b(P_PCEN), 0, 0, o, f, "JUMP");
                default: begin
                    a  = (o == OP_ORI) ? 3'b001 : 3'b010;
                    oi = (o == OP_IN) ? b(P_ORI) : 16'h0;
                    step(b(P_SA) | sb(2'b10) | ac(a) | oi, 0, 0, o, f, "IEXEC");
                    step(b(P_RW) | ac(a) | oi, 0, 0, o, f, "IWB");
                end
            endcase
            cnt = cnt + 1;
        end
    endtask

    task automatic run_random();
        logic [5:0] o;
        logic [5:0] f;
        logic [5:0] fl[5];
        int         k;
        fl[0] = F_ADD; fl[1] = F_SUB; fl[2] = F_AND; fl[3] = F_OR; fl[4] = F_SLT;
        f = fl[$urandom_range(0, 4)];
        k = $urandom_range(0, 10);
        case (k)
            0: o = OP_LW;
            1: o = OP_SW;
            2, 3: o = OP_R;
            4: o = OP_BEQ;
            5: o = OP_ADDI;
            6: o = OP_ORI;
            7: o = OP_IN;
            8: o = OP_J;
            9: begin
                o = OP_R;
                do f = 6'($urandom); while (legal_funct(f));
            end
            default: begin
                do o = 6'($urandom); while (legal_op(o));
            end
        endcase
        run_instr(o, f);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            m_e   = q.pop_front();
            m_act = {bus.PCen, bus.IorD, bus.Ori, bus.MemWrite, bus.IRWrite, bus.RegDst,
                     bus.MemtoReg, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl,
                     bus.PCsrc, bus.illegal_o};
            checks++;
            if (m_act !== m_e.v || bus.instr_count_o !== m_e.c) begin
                errors++;
                $display("FAIL %s at %0t: ctrl=%b count=%0d, expected ctrl=%b count=%0d",
                         m_e.tag, $time, m_act, bus.instr_count_o, m_e.v, m_e.c);
            end
        end
    end

    initial begin
        reset      = 1'b0;
        bus.op     = '0;
        bus.Funct  = '0;
        bus.zero_i = 1'b0;

        repeat (3) step(16'h0, 0, 0, 6'h0, 6'h0, "RESET");
        step(16'h0, 0, 0, 6'h0, 6'h0, "INIT");
        reset = 1'b1;

        run_instr(OP_LW, 6'($urandom));
        run_instr(OP_R, F_SUB);
        run_instr(OP_R, F_SLT);
        force_zero = 1;
        run_instr(OP_BEQ, 6'($urandom));
        force_zero = 0;
        run_instr(OP_BEQ, 6'($urandom));
        force_zero = -1;
        run_instr(OP_IN, 6'($urandom));
        run_instr(OP_ORI, 6'($urandom));
        run_instr(6'b010101, 6'($urandom));
        run_instr(OP_R, 6'b111000);

        repeat (40) run_random();

        // Reset lands while a store is in MEMWRITE: strobe and count must clear in that cycle.
        step(b(P_PCEN) | b(P_IRW) | sb(2'b01) | ac(3'b010), 0, 0, OP_SW, 6'h0, "FETCH");
        step(sb(2'b11) | ac(3'b010), 0, 1, OP_SW, 6'h0, "DECODE");
        step(b(P_SA) | sb(2'b10) | ac(3'b010), 0, 0, OP_SW, 6'h0, "MEMADR");
        cnt = '0;
        step(16'h0, 0, 0, 6'h0, 6'h0, "MIDRST");
        reset = 1'b0;
        step(16'h0, 0, 0, 6'h0, 6'h0, "RESET");
        step(16'h0, 0, 0, 6'h0, 6'h0, "INIT");
        reset = 1'b1;

        repeat (10) run_random();

        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
